// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID register: owns the PC and keeps one imem request in flight.
// A one-entry skid buffer catches a response that arrives while decode is stalled.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] IF_ID_pc,
  output logic [31:0]     IF_ID_inst,
  output logic            IF_ID_valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            buf_valid_q, buf_valid_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]     buf_inst_q, buf_inst_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]     if_id_inst_q, if_id_inst_d;

  logic handshake;
  logic resp_good;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a returning response always ends the outstanding request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (handshake) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)   state_d = S_REQ;
        else if (redirect) state_d = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req  = (state_q == S_REQ) && !buf_valid_q && !redirect;
    imem_addr = pc_q;
    handshake = imem_req && imem_ready;
    resp_good = (state_q == S_WAIT) && imem_rvalid;
  end

  // Datapath: PC, skid buffer and IF/ID
  always_comb begin
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    buf_valid_d   = buf_valid_q;
    buf_pc_d      = buf_pc_q;
    buf_inst_d    = buf_inst_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;

    if (redirect) begin
      pc_d          = redirect_pc;
      buf_valid_d   = 1'b0;
      if_id_valid_d = 1'b0;
      if_id_inst_d  = NOP_INST;
    end else begin
      if (handshake) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + XLEN'(4);
      end
      if (stall) begin
        if (resp_good) begin
          buf_valid_d = 1'b1;
          buf_pc_d    = req_pc_q;
          buf_inst_d  = imem_rdata;
        end
      end else if (buf_valid_q) begin
        buf_valid_d   = 1'b0;
        if_id_valid_d = 1'b1;
        if_id_pc_d    = buf_pc_q;
        if_id_inst_d  = buf_inst_q;
      end else if (resp_good) begin
        if_id_valid_d = 1'b1;
        if_id_pc_d    = req_pc_q;
        if_id_inst_d  = imem_rdata;
      end else begin
        if_id_valid_d = 1'b0;
        if_id_inst_d  = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      buf_valid_q   <= 1'b0;
      buf_pc_q      <= '0;
      buf_inst_q    <= NOP_INST;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= NOP_INST;
    end else begin
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      buf_valid_q   <= buf_valid_d;
      buf_pc_q      <= buf_pc_d;
      buf_inst_q    <= buf_inst_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
    end
  end

  assign IF_ID_valid = if_id_valid_q;
  assign IF_ID_pc    = if_id_pc_q;
  assign IF_ID_inst  = if_id_inst_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized traffic, all checked against
// a transaction-level model (PC, in-flight request list, pending-instruction queue).
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_ready, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, IF_ID_valid;
  logic [31:0] imem_addr, IF_ID_pc, IF_ID_inst;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst), .IF_ID_valid(IF_ID_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          known = 0;
  logic [31:0] m_pc;
  bit          m_out;
  logic [31:0] m_out_pc;
  bit          m_out_drop;
  logic [31:0] m_pending[$];
  bit          m_valid;
  logic [31:0] m_ifid_pc, m_ifid_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h00500093;
    else if (a == 32'h8) return 32'h00208133;
    else                 return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_out = 0; m_out_pc = 32'h0; m_out_drop = 0;
    m_pending.delete();
    m_valid = 0; m_ifid_pc = 32'h0; m_ifid_inst = NOP;
  endtask

  // One clock cycle: drive at negedge, check fetch side, model the edge, check IF/ID.
  task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] rpc,
                      input bit rdy, input bit rv);
    bit exp_req, hs, resp, good;
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    imem_ready = rdy; imem_rvalid = rv;
    imem_rdata = (rv && m_out) ? mem_word(m_out_pc) : 32'hbad0bad0;
    exp_req = !m_out && (m_pending.size() == 0) && !rd;
    #1;
    if (known) begin
      check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      check("imem_addr", imem_addr, m_pc);
    end
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
      known = 1;
    end else if (known) begin
      resp = m_out && rv;
      good = resp && !m_out_drop;
      hs   = exp_req && rdy;
      if (rd) begin
        m_pc = rpc;
        m_pending.delete();
        m_valid = 0; m_ifid_inst = NOP;
        if (resp) m_out = 0;
        else if (m_out) m_out_drop = 1;
      end else begin
        if (resp) m_out = 0;
        if (hs) begin
          m_out = 1; m_out_pc = m_pc; m_out_drop = 0;
          m_pc = m_pc + 32'd4;
        end
        if (s) begin
          if (good) m_pending.push_back(m_out_pc);
        end else if (m_pending.size() > 0) begin
          m_ifid_pc = m_pending.pop_front();
          m_valid = 1; m_ifid_inst = mem_word(m_ifid_pc);
        end else if (good) begin
          m_valid = 1; m_ifid_pc = m_out_pc; m_ifid_inst = mem_word(m_out_pc);
        end else begin
          m_valid = 0; m_ifid_inst = NOP;
        end
      end
    end
    if (known) begin
      check("IF_ID_valid", {31'b0, IF_ID_valid}, {31'b0, m_valid});
      check("IF_ID_pc", IF_ID_pc, m_ifid_pc);
      check("IF_ID_inst", IF_ID_inst, m_ifid_inst);
    end
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;

    // 1: reset and first fetch
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rst_valid", {31'b0, IF_ID_valid}, 32'd0);
    check("rst_inst", IF_ID_inst, NOP);
    check("rst_addr", imem_addr, 32'h0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    check("t1_pc", IF_ID_pc, 32'h0);
    check("t1_inst", IF_ID_inst, 32'h00500093);
    check("t1_next_addr", imem_addr, 32'h4);

    // 2: response lands in skid buffer during a 3-cycle stall
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    check("t2_hold_pc", IF_ID_pc, 32'h4);
    step(0, 0, 0, 0, 1, 0);
    check("t2_pc", IF_ID_pc, 32'h8);
    check("t2_inst", IF_ID_inst, 32'h00208133);
    check("t2_next_addr", imem_addr, 32'hC);

    // 3: redirect while waiting, late response dropped
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 32'h100, 0, 0);
    check("t3_valid", {31'b0, IF_ID_valid}, 32'd0);
    check("t3_inst", IF_ID_inst, NOP);
    step(0, 0, 0, 0, 1, 1);
    check("t3_addr", imem_addr, 32'h100);

    // 4: redirect together with stall flushes the buffered entry
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 1, 32'h200, 0, 0);
    check("t4_valid", {31'b0, IF_ID_valid}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    check("t4_after", {31'b0, IF_ID_valid}, 32'd0);

    // 5: imem not ready for 4 cycles
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    check("t5_addr", imem_addr, 32'h200);

    // 6: reset in WAIT with a stale response afterwards
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check("t6_valid", {31'b0, IF_ID_valid}, 32'd0);
    check("t6_addr", imem_addr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, s, rd, rdy, rv;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      rv  = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : ($urandom() & 32'hFFFFFFFC);
      step(r, s, rd, rpc, rdy, rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
